// File: rtl/cache_miss_fsm.sv
// -----------------------------------------------------------------------------
// cache_miss_fsm
//
// Cache-side miss handler for the memory stage. This block drives the cache
// stall input of the hazard unit. On a load/store miss it takes these steps:
//   1. If the victim line is dirty, write it back one word per beat.
//   2. Issue a single read burst request for the missing line.
//   3. Fill the line one word per returned beat, writing the tag with the last
//      word.
//   4. Spend one settle cycle so that the refilled line can be looked up as a
//      hit.
// The stall stays high until the FSM is back in IDLE.
//
// Optional build macro:
//   CACHE_MISS_PERF_CNT_EN - adds saturating 32-bit hit/miss counters and the
//                            o_hit_cnt / o_miss_cnt ports.
//
// Ports:
//   i_clk, i_arstn       clock (rising edge), asynchronous active-low reset
//   i_mem_access         load or store present in the memory stage
//   i_hit                combinational tag hit for i_addr
//   i_dirty              selected victim line is valid and dirty
//   i_addr               access byte address
//   i_victim_addr        base address of the victim line
//   i_rd_req_ready       memory accepts the read burst request
//   i_rd_valid           read data beat valid
//   i_wr_ready           memory accepts the current write beat
//   o_stall_cache        stall request to the hazard unit
//   o_rd_req             read burst request
//   o_wr_valid           write beat valid
//   o_wr_last            final write beat of the line
//   o_mem_addr           line-aligned burst address
//   o_word_idx           array word index (read for writeback, write for fill)
//   o_fill_we            write the current read beat into the data array
//   o_tag_we             write tag, set valid, clear dirty
//   o_hit_cnt            (optional) saturating IDLE hit count
//   o_miss_cnt           (optional) saturating miss count
// -----------------------------------------------------------------------------
module cache_miss_fsm #(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BLOCK_WORD_CNT = 16,
  parameter int unsigned WORD_CNT_W     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_arstn,
  input  logic                  i_mem_access,
  input  logic                  i_hit,
  input  logic                  i_dirty,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [ADDR_W-1:0]     i_victim_addr,
  input  logic                  i_rd_req_ready,
  input  logic                  i_rd_valid,
  input  logic                  i_wr_ready,
  output logic                  o_stall_cache,
  output logic                  o_rd_req,
  output logic                  o_wr_valid,
  output logic                  o_wr_last,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [WORD_CNT_W-1:0] o_word_idx,
  output logic                  o_fill_we,
  output logic                  o_tag_we
`ifdef CACHE_MISS_PERF_CNT_EN
  ,
  output logic [31:0]           o_hit_cnt,
  output logic [31:0]           o_miss_cnt
`endif
);

  // Number of byte-offset bits inside one cache line.
  localparam int unsigned OFS = $clog2(BLOCK_WORD_CNT * DATA_W / 8);

  // Clears the line-offset bits of a byte address.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFS) - ADDR_W'(1));

  localparam logic [WORD_CNT_W-1:0] LAST_IDX = WORD_CNT_W'(BLOCK_WORD_CNT - 1);
  localparam logic [WORD_CNT_W-1:0] ONE_IDX  = WORD_CNT_W'(1);

  // FSM encoding
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WB       = 3'd1;
  localparam logic [2:0] FILL_REQ = 3'd2;
  localparam logic [2:0] FILL     = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [WORD_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]     fill_addr_q, fill_addr_d;
  logic [ADDR_W-1:0]     victim_addr_q, victim_addr_d;

  logic miss;
  logic cnt_last;

  // The miss edge: only IDLE can accept a new miss.
  assign miss     = (state_q == IDLE) & i_mem_access & ~i_hit;
  assign cnt_last = (cnt_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_addr_d   = fill_addr_q;
    victim_addr_d = victim_addr_q;

    case (state_q)
      IDLE: begin
        if (miss) begin
          // Capture both burst addresses so the pipeline may change them.
          fill_addr_d   = i_addr & LINE_MASK;
          victim_addr_d = i_victim_addr;
          cnt_d         = '0;
          state_d       = i_dirty ? WB : FILL_REQ;
        end
      end

      WB: begin
        // o_wr_valid is always high here, so i_wr_ready alone marks a transfer.
        if (i_wr_ready) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = FILL_REQ;
          end else begin
            cnt_d = cnt_q + ONE_IDX;
          end
        end
      end

      FILL_REQ: begin
        if (i_rd_req_ready) begin
          state_d = FILL;
        end
      end

      FILL: begin
        if (i_rd_valid) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ONE_IDX;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      fill_addr_q   <= '0;
      victim_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fill_addr_q   <= fill_addr_d;
      victim_addr_q <= victim_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_stall_cache = 1'b1;
    o_rd_req      = 1'b0;
    o_wr_valid    = 1'b0;
    o_wr_last     = 1'b0;
    o_mem_addr    = '0;
    o_word_idx    = '0;
    o_fill_we     = 1'b0;
    o_tag_we      = 1'b0;

    case (state_q)
      IDLE: begin
        // Raise the stall in the detection cycle. Gate it with the reset so
        // that every output reads 0 while reset is held, even with a miss
        // pending at the inputs.
        o_stall_cache = i_arstn & i_mem_access & ~i_hit;
      end

      WB: begin
        o_mem_addr = victim_addr_q;
        o_wr_valid = 1'b1;
        o_wr_last  = cnt_last;
        o_word_idx = cnt_q;
      end

      FILL_REQ: begin
        o_mem_addr = fill_addr_q;
        o_rd_req   = 1'b1;
      end

      FILL: begin
        o_mem_addr = fill_addr_q;
        o_word_idx = cnt_q;
        o_fill_we  = i_rd_valid;
        o_tag_we   = i_rd_valid & cnt_last;
      end

      DONE: begin
        // Hold the stall for one cycle while the array read settles.
      end

      default: begin
        o_stall_cache = 1'b0;
      end
    endcase
  end

`ifdef CACHE_MISS_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        idle_hit;

  assign idle_hit = (state_q == IDLE) & i_mem_access & i_hit;

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_miss_fsm.sv
module tb_cache_miss_fsm;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BWC    = 16;
  localparam int unsigned WCW    = 4;
  localparam logic [63:0] LINE_M1 = 64'(BWC * DATA_W / 8 - 1);

  logic              i_clk;
  logic              i_arstn;
  logic              i_mem_access;
  logic              i_hit;
  logic              i_dirty;
  logic [ADDR_W-1:0] i_addr;
  logic [ADDR_W-1:0] i_victim_addr;
  logic              i_rd_req_ready;
  logic              i_rd_valid;
  logic              i_wr_ready;
  logic              o_stall_cache;
  logic              o_rd_req;
  logic              o_wr_valid;
  logic              o_wr_last;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [WCW-1:0]    o_word_idx;
  logic              o_fill_we;
  logic              o_tag_we;
`ifdef CACHE_MISS_PERF_CNT_EN
  logic [31:0]       o_hit_cnt;
  logic [31:0]       o_miss_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  cache_miss_fsm #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .BLOCK_WORD_CNT(BWC),
    .WORD_CNT_W    (WCW)
  ) dut (
    .i_clk         (i_clk),
    .i_arstn       (i_arstn),
    .i_mem_access  (i_mem_access),
    .i_hit         (i_hit),
    .i_dirty       (i_dirty),
    .i_addr        (i_addr),
    .i_victim_addr (i_victim_addr),
    .i_rd_req_ready(i_rd_req_ready),
    .i_rd_valid    (i_rd_valid),
    .i_wr_ready    (i_wr_ready),
    .o_stall_cache (o_stall_cache),
    .o_rd_req      (o_rd_req),
    .o_wr_valid    (o_wr_valid),
    .o_wr_last     (o_wr_last),
    .o_mem_addr    (o_mem_addr),
    .o_word_idx    (o_word_idx),
    .o_fill_we     (o_fill_we),
    .o_tag_we      (o_tag_we)
`ifdef CACHE_MISS_PERF_CNT_EN
    ,
    .o_hit_cnt     (o_hit_cnt),
    .o_miss_cnt    (o_miss_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    i_mem_access   = 1'b0;
    i_hit          = 1'b0;
    i_dirty        = 1'b0;
    i_addr         = '0;
    i_victim_addr  = '0;
    i_rd_req_ready = 1'b0;
    i_rd_valid     = 1'b0;
    i_wr_ready     = 1'b0;
  endtask

  // Leaves the bench just after a rising edge with reset released.
  task automatic do_reset();
    clear_inputs();
    i_arstn = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    #1 i_arstn = 1'b1;
    @(posedge i_clk);
    #1;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Plays one whole miss at transaction level. The memory-side handshakes
  // are chosen per cycle, and the bench tracks which phase the line transfer
  // should be in: writeback beats, the request, fill beats, then the settle
  // cycle. stall_cnt counts the cycles where o_stall_cache was observed
  // high, starting with the detection cycle.
  task automatic run_miss(input logic [63:0] addr, input logic [63:0] victim, input bit dirty,
                          input int wr_mode, input int req_wait, input bit fill_rand,
                          input int abort_word, output int stall_cnt);
    logic [63:0] fill_exp;
    int phase;
    int idx;
    int reqc;
    int cyc;
    bit tog;
    bit aborted;
    fill_exp  = addr & ~LINE_M1;
    phase     = dirty ? 0 : 1;
    idx       = 0;
    reqc      = 0;
    cyc       = 0;
    tog       = 1'b1;
    aborted   = 1'b0;
    stall_cnt = 0;

    // Detection cycle
    clear_inputs();
    i_mem_access  = 1'b1;
    i_dirty       = dirty;
    i_addr        = addr;
    i_victim_addr = victim;
    @(negedge i_clk);
    checks++;
    if (o_stall_cache !== 1'b1) begin
      errors++; $display("FAIL detect_stall: got %0b want 1", o_stall_cache);
    end
    checks++;
    if ((o_rd_req | o_wr_valid | o_fill_we | o_tag_we) !== 1'b0) begin
      errors++; $display("FAIL detect_quiet: got rd_req=%0b wr_valid=%0b want 0", o_rd_req, o_wr_valid);
    end
    if (o_stall_cache === 1'b1) stall_cnt++;
    exp_misses++;
    @(posedge i_clk);
    #1;
    // The captured addresses must not follow later changes on the inputs.
    i_addr        = {$urandom, $urandom};
    i_victim_addr = {$urandom, $urandom};
    i_dirty       = ~dirty;

    while (phase != 4 && cyc < 2000) begin
      cyc++;
      case (phase)
        0: begin
          i_wr_ready     = (wr_mode == 1) ? tog : ((wr_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1)));
          tog            = ~tog;
          i_rd_valid     = 1'($urandom_range(0, 1));
          i_rd_req_ready = 1'b0;
        end
        1: begin
          i_wr_ready     = 1'($urandom_range(0, 1));
          i_rd_valid     = 1'($urandom_range(0, 1));
          i_rd_req_ready = (req_wait < 0) ? 1'($urandom_range(0, 1)) : (reqc >= req_wait);
        end
        2: begin
          i_wr_ready     = 1'($urandom_range(0, 1));
          i_rd_valid     = fill_rand ? 1'($urandom_range(0, 1)) : 1'b1;
          i_rd_req_ready = 1'b0;
        end
        default: begin
          i_wr_ready     = 1'($urandom_range(0, 1));
          i_rd_valid     = 1'($urandom_range(0, 1));
          i_rd_req_ready = 1'($urandom_range(0, 1));
        end
      endcase

      if (phase == 2 && idx == abort_word) begin
        i_arstn = 1'b0;
        #2;
        checks++;
        if (o_stall_cache !== 1'b0) begin
          errors++; $display("FAIL abort_stall: got %0b want 0", o_stall_cache);
        end
        checks++;
        if ({o_rd_req, o_wr_valid, o_wr_last, o_fill_we, o_tag_we} !== 5'b0) begin
          errors++; $display("FAIL abort_ctrl: got %05b want 00000",
                             {o_rd_req, o_wr_valid, o_wr_last, o_fill_we, o_tag_we});
        end
        checks++;
        if (o_mem_addr !== 64'h0 || o_word_idx !== 4'h0) begin
          errors++; $display("FAIL abort_addr: got addr=%0h idx=%0d want 0", o_mem_addr, o_word_idx);
        end
        @(negedge i_clk);
        clear_inputs();
        #1 i_arstn = 1'b1;
        aborted = 1'b1;
        phase   = 4;
      end else begin
        @(negedge i_clk);
        checks++;
        if (o_stall_cache !== 1'b1) begin
          errors++; $display("FAIL busy_stall: phase %0d got %0b want 1", phase, o_stall_cache);
        end
        if (o_stall_cache === 1'b1) stall_cnt++;
        case (phase)
          0: begin
            checks++;
            if (o_wr_valid !== 1'b1 || o_word_idx !== 4'(idx) || o_wr_last !== (idx == BWC - 1)) begin
              errors++; $display("FAIL wb_beat: got valid=%0b idx=%0d last=%0b want 1 %0d %0b",
                                 o_wr_valid, o_word_idx, o_wr_last, idx, idx == BWC - 1);
            end
            checks++;
            if (o_mem_addr !== victim || o_rd_req !== 1'b0 || o_fill_we !== 1'b0) begin
              errors++; $display("FAIL wb_addr: got addr=%0h rd_req=%0b fill_we=%0b want %0h 0 0",
                                 o_mem_addr, o_rd_req, o_fill_we, victim);
            end
            if (i_wr_ready) begin
              idx++;
              if (idx == BWC) begin
                idx   = 0;
                phase = 1;
              end
            end
          end
          1: begin
            checks++;
            if (o_rd_req !== 1'b1 || o_mem_addr !== fill_exp) begin
              errors++; $display("FAIL fill_req: got req=%0b addr=%0h want 1 %0h",
                                 o_rd_req, o_mem_addr, fill_exp);
            end
            checks++;
            if (o_wr_valid !== 1'b0 || o_fill_we !== 1'b0 || o_tag_we !== 1'b0) begin
              errors++; $display("FAIL req_quiet: got wr_valid=%0b fill_we=%0b want 0 0",
                                 o_wr_valid, o_fill_we);
            end
            if (i_rd_req_ready) phase = 2;
            else reqc++;
          end
          2: begin
            checks++;
            if (o_fill_we !== i_rd_valid || o_tag_we !== (i_rd_valid && idx == BWC - 1)) begin
              errors++; $display("FAIL fill_we: got we=%0b tag=%0b want %0b %0b", o_fill_we,
                                 o_tag_we, i_rd_valid, i_rd_valid && idx == BWC - 1);
            end
            checks++;
            if ((i_rd_valid && o_word_idx !== 4'(idx)) || o_rd_req !== 1'b0 || o_wr_valid !== 1'b0) begin
              errors++; $display("FAIL fill_idx: got idx=%0d req=%0b wr=%0b want %0d 0 0",
                                 o_word_idx, o_rd_req, o_wr_valid, idx);
            end
            if (i_rd_valid) begin
              idx++;
              if (idx == BWC) begin
                idx   = 0;
                phase = 3;
              end
            end
          end
          default: begin
            checks++;
            if ({o_rd_req, o_wr_valid, o_fill_we, o_tag_we} !== 4'b0) begin
              errors++; $display("FAIL done_quiet: got %04b want 0000",
                                 {o_rd_req, o_wr_valid, o_fill_we, o_tag_we});
            end
            phase = 4;
          end
        endcase
      end
      @(posedge i_clk);
      #1;
    end

    if (cyc >= 2000) begin
      errors++; $display("FAIL miss_timeout: got %0d cycles want completion", cyc);
    end

    if (!aborted) begin
      // The line is now present: the replayed access hits and the stall drops.
      clear_inputs();
      i_mem_access = 1'b1;
      i_hit        = 1'b1;
      @(negedge i_clk);
      checks++;
      if (o_stall_cache !== 1'b0 || o_rd_req !== 1'b0 || o_wr_valid !== 1'b0) begin
        errors++; $display("FAIL replay_hit: got stall=%0b req=%0b wr=%0b want 0 0 0",
                           o_stall_cache, o_rd_req, o_wr_valid);
      end
      exp_hits++;
      @(posedge i_clk);
      #1;
      clear_inputs();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    i_arstn      = 1'b0;
    i_mem_access = 1'b1;
    i_hit        = 1'b1;
    #3;
    checks++;
    if ({o_stall_cache, o_rd_req, o_wr_valid, o_wr_last, o_fill_we, o_tag_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %06b want 000000",
                         {o_stall_cache, o_rd_req, o_wr_valid, o_wr_last, o_fill_we, o_tag_we});
    end
    checks++;
    if (o_mem_addr !== 64'h0 || o_word_idx !== 4'h0) begin
      errors++; $display("FAIL reset_addr: got addr=%0h idx=%0d want 0 0", o_mem_addr, o_word_idx);
    end
    @(negedge i_clk);
    #1 i_arstn = 1'b1;
    @(posedge i_clk);
    #1;
    exp_hits   = 0;
    exp_misses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      checks++;
      if ({o_stall_cache, o_rd_req, o_wr_valid, o_fill_we, o_tag_we} !== 5'b0) begin
        errors++; $display("FAIL reset_hit: got %05b want 00000",
                           {o_stall_cache, o_rd_req, o_wr_valid, o_fill_we, o_tag_we});
      end
      exp_hits++;
      @(posedge i_clk);
      #1;
    end
    clear_inputs();
  endtask

  task automatic test_hits();
    for (int i = 0; i < 40; i++) begin
      i_mem_access   = 1'($urandom_range(0, 1));
      i_hit          = i_mem_access ? 1'b1 : 1'($urandom_range(0, 1));
      i_dirty        = 1'($urandom_range(0, 1));
      i_addr         = {$urandom, $urandom};
      i_rd_valid     = 1'($urandom_range(0, 1));
      i_wr_ready     = 1'($urandom_range(0, 1));
      i_rd_req_ready = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      checks++;
      if ({o_stall_cache, o_rd_req, o_wr_valid, o_fill_we, o_tag_we} !== 5'b0) begin
        errors++; $display("FAIL hit_idle: got %05b want 00000",
                           {o_stall_cache, o_rd_req, o_wr_valid, o_fill_we, o_tag_we});
      end
      if (i_mem_access) exp_hits++;
      @(posedge i_clk);
      #1;
    end
    clear_inputs();
  endtask

  task automatic test_clean_miss();
    int sc;
    run_miss(64'h1234, 64'h0, 1'b0, 2, 0, 1'b0, -1, sc);
    checks++;
    if (sc !== 1 + 1 + BWC + 1) begin
      errors++; $display("FAIL clean_penalty: got %0d want %0d", sc, 1 + 1 + BWC + 1);
    end
  endtask

  task automatic test_dirty_miss();
    int sc;
    run_miss(64'h1234, 64'h8000, 1'b1, 1, 0, 1'b0, -1, sc);
    checks++;
    if (sc !== 1 + (2 * BWC - 1) + 1 + BWC + 1) begin
      errors++; $display("FAIL dirty_penalty: got %0d want %0d", sc, 1 + (2 * BWC - 1) + 1 + BWC + 1);
    end
    run_miss(64'h0000_0042_0000_10FC, 64'h0000_0042_0000_7FC0, 1'b1, 2, 0, 1'b0, -1, sc);
    checks++;
    if (sc !== 1 + BWC + 1 + BWC + 1) begin
      errors++; $display("FAIL dirty_zero_wait: got %0d want %0d", sc, 1 + BWC + 1 + BWC + 1);
    end
  endtask

  task automatic test_req_wait();
    int sc;
    run_miss(64'hABCD_EF01, 64'h0, 1'b0, 2, 5, 1'b0, -1, sc);
    checks++;
    if (sc !== 1 + 6 + BWC + 1) begin
      errors++; $display("FAIL req_wait_penalty: got %0d want %0d", sc, 1 + 6 + BWC + 1);
    end
  endtask

  task automatic test_reset_mid_fill();
    int sc;
    run_miss(64'h5555_0077, 64'h0, 1'b0, 2, 0, 1'b0, 7, sc);
    exp_hits   = 0;
    exp_misses = 0;
    run_miss(64'h5555_0077, 64'h0, 1'b0, 2, 0, 1'b0, -1, sc);
    checks++;
    if (sc !== 1 + 1 + BWC + 1) begin
      errors++; $display("FAIL restart_penalty: got %0d want %0d", sc, 1 + 1 + BWC + 1);
    end
  endtask

  task automatic test_random_misses();
    int sc;
    logic [63:0] a;
    logic [63:0] v;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      v = {$urandom, $urandom} & ~LINE_M1;
      run_miss(a, v, 1'($urandom_range(0, 1)), 0, -1, 1'b1, -1, sc);
    end
  endtask

`ifdef CACHE_MISS_PERF_CNT_EN
  task automatic test_perf();
    int sc;
    do_reset();
    checks++;
    if (o_hit_cnt !== 32'd0 || o_miss_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_reset: got %0d %0d want 0 0", o_hit_cnt, o_miss_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      i_mem_access = 1'b1;
      i_hit        = 1'b1;
      exp_hits++;
      @(posedge i_clk);
      #1;
    end
    clear_inputs();
    @(negedge i_clk);
    checks++;
    if (o_hit_cnt !== 32'd3 || o_miss_cnt !== 32'd0) begin
      errors++; $display("FAIL perf_hits: got %0d %0d want 3 0", o_hit_cnt, o_miss_cnt);
    end
    @(posedge i_clk);
    #1;
    run_miss(64'h1000, 64'h2000, 1'b1, 2, 0, 1'b0, -1, sc);
    run_miss(64'h3000, 64'h0, 1'b0, 2, 0, 1'b0, -1, sc);
    @(negedge i_clk);
    checks++;
    if (o_hit_cnt !== 32'(exp_hits) || o_miss_cnt !== 32'(exp_misses)) begin
      errors++; $display("FAIL perf_counts: got %0d %0d want %0d %0d", o_hit_cnt, o_miss_cnt,
                         exp_hits, exp_misses);
    end
    @(posedge i_clk);
    #1;
  endtask
`endif

  initial begin
    clear_inputs();
    i_arstn = 1'b1;
    #1;
    test_reset();
    test_hits();
    test_clean_miss();
    test_dirty_miss();
    test_req_wait();
    test_reset_mid_fill();
    test_random_misses();
`ifdef CACHE_MISS_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_miss_fsm.md
Name: cache_miss_fsm

Overview:
- Cache-side control FSM in the memory stage; the upstream producer of the hazard unit's cache-stall input.
- On a load/store miss it writes back a dirty victim line if there is one. It then refills the line from memory, one beat per word.
- It holds the stall high until the refilled line can be looked up as a hit.
- Used once for the data cache and optionally once for the instruction cache.

Parameters:
ADDR_W, 64, byte address width.
DATA_W, 32, memory beat and cache word width.
BLOCK_WORD_CNT, 16, words per cache line; power of two, at least 2.
WORD_CNT_W, 4, log2(BLOCK_WORD_CNT).

Ports:
i_clk  in  1  clock, rising edge.
i_arstn  in  1  asynchronous active-low reset.
i_mem_access  in  1  load or store present in the memory stage.
i_hit  in  1  tag lookup hit for i_addr, combinational from the cache.
i_dirty  in  1  selected victim line is valid and dirty.
i_addr  in  ADDR_W  access byte address.
i_victim_addr  in  ADDR_W  base address of the victim line.
i_rd_req_ready  in  1  memory accepts the read request.
i_rd_valid  in  1  read data beat valid.
i_wr_ready  in  1  memory accepts the write beat.
o_stall_cache  out  1  stall request to the hazard unit.
o_rd_req  out  1  read burst request.
o_wr_valid  out  1  write beat valid.
o_wr_last  out  1  final write beat.
o_mem_addr  out  ADDR_W  line-aligned burst address.
o_word_idx  out  WORD_CNT_W  word index for the array read (writeback) or array write (fill).
o_fill_we  out  1  write i_rd_data word into the array (the data path is external).
o_tag_we  out  1  write tag, set valid, clear dirty.

Behaviour:
- States: IDLE, WB, FILL_REQ, FILL, DONE. Reset is asynchronous.
- Reset value: state IDLE, counter 0, all outputs 0.
- Reset asserted mid-burst returns to IDLE immediately. The burst is abandoned; memory shares the same reset.
- OFS = log2(BLOCK_WORD_CNT*DATA_W/8) line-offset bits.
- Fill address = i_addr with the low OFS bits zeroed.
- Both addresses (fill address and i_victim_addr) are captured into registers on the miss edge.

IDLE:
- o_stall_cache = i_mem_access & ~i_hit. This is combinational, so the stall is raised in the same cycle the miss is detected.
- On a miss: go to WB if i_dirty, otherwise go to FILL_REQ. The counter is cleared on either transition.

WB:
- o_mem_addr = victim address.
- o_wr_valid = 1 and o_word_idx = counter.
- A beat transfers when o_wr_valid & i_wr_ready. The counter increments only on a transfer.
- o_wr_last = counter == BLOCK_WORD_CNT-1.
- A transfer with o_wr_last set goes to FILL_REQ, and the counter wraps to 0.

FILL_REQ:
- o_rd_req = 1 and o_mem_addr = fill address. Both hold until i_rd_req_ready.
- On the handshake cycle go to FILL.

FILL:
- Each i_rd_valid gives o_fill_we = 1 combinationally, with o_word_idx = counter; the counter then increments.
- On the last beat (counter == BLOCK_WORD_CNT-1), o_tag_we pulses in the same cycle and the FSM goes to DONE.
- Gaps in i_rd_valid are allowed; the state holds.

DONE:
- One cycle with stall still high; the array read settles.
- Then go to IDLE. In IDLE the stall drops in the next cycle if i_hit.

General rules:
- o_stall_cache = 1 in every non-IDLE state.
- i_rd_valid outside FILL and i_wr_ready outside WB are ignored.
- A new miss cannot be accepted until back in IDLE.
- Total miss penalty, clean line, zero-wait memory: 1 (FILL_REQ) + BLOCK_WORD_CNT + 1 (DONE) stall cycles after the detection cycle.
- A dirty victim adds BLOCK_WORD_CNT cycles.

Optional Feature:
Macro CACHE_MISS_PERF_CNT_EN.
- When defined: adds outputs o_hit_cnt (32 bits) and o_miss_cnt (32 bits), both reset to 0.
  - o_hit_cnt increments on IDLE & i_mem_access & i_hit.
  - o_miss_cnt increments on each IDLE miss edge.
  - Both saturate at 0xFFFFFFFF.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset asserted, then i_mem_access=1, i_hit=1 -> o_stall_cache=0, no memory activity, state stays IDLE.
2. Clean miss, i_addr=0x1234, zero-wait memory:
   - o_mem_addr=0x1200 and o_rd_req held for one cycle.
   - 16 o_fill_we pulses with o_word_idx 0..15, and o_tag_we with idx 15.
   - o_stall_cache high for 19 cycles including the detection cycle.
3. Dirty miss, i_victim_addr=0x8000, i_wr_ready toggling 1,0,1,0:
   - 16 write beats with idx 0..15 and o_wr_last only on beat 15.
   - The counter holds while i_wr_ready=0.
   - Then the fill sequence of test 2 follows.
4. i_rd_req_ready held 0 for 5 cycles -> o_rd_req and o_mem_addr stable for 5 cycles; a spurious i_rd_valid in FILL_REQ is ignored.
5. i_arstn pulsed low during FILL at word 7 -> all outputs 0 asynchronously, state IDLE. A subsequent miss restarts at word 0.
6. With CACHE_MISS_PERF_CNT_EN: 3 hits and 2 misses -> o_hit_cnt=3, o_miss_cnt=2. With the counter preset near 0xFFFFFFFF it saturates at 0xFFFFFFFF.
